fp_addsub_issue_ctrl: RTL and testbench

Initiator for the team's pipelined single-precision adder/subtractor wrapper, which is a fixed-latency block with a hold-on-valid output.
- On a start pulse, reads LEN operand pairs from the A/B operand RAMs and issues one pair per cycle with a common op.
- Tracks each issue through a LATENCY-deep valid delay line and drives the adder's result-valid/hold strobe.
- Writes each returned result to the result RAM, then pulses done.
- Sits between the Jacobi iteration controller and the adder instance.

---
 rtl/fp_feeder_pkg.sv | 15 +
 rtl/valid_delay_line.sv | 27 ++
 rtl/fp_addsub_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_fp_addsub_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_feeder_pkg.sv
// Shared definitions for the FP adder feeder: state encoding, data width
// and the adder wrapper's default pipeline latency.
package fp_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned FP_W            = 32;
    localparam int unsigned DEFAULT_LATENCY = 8;

endpackage

// File: rtl/valid_delay_line.sv
// LATENCY-deep shift register that tracks issued operand pairs through the
// adder pipeline; cleared by rst so in-flight results are never written.
module valid_delay_line #(
    parameter int unsigned LATENCY = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    output logic out_bit
);

    logic [LATENCY-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= in_bit;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign out_bit = r_sr[LATENCY-1];

endmodule

// File: rtl/fp_addsub_issue_ctrl.sv
// Reads LEN operand pairs, issues them to the fixed-latency FP add/sub and
// writes the results back. Optional read stall input: FEEDER_STALL_EN.
module fp_addsub_issue_ctrl
    import fp_feeder_pkg::*;
#(
    parameter int unsigned LATENCY = DEFAULT_LATENCY,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              op_in,
`ifdef FEEDER_STALL_EN
    input  logic              stall,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [FP_W-1:0]   rd_data_a,
    input  logic [FP_W-1:0]   rd_data_b,
    output logic [FP_W-1:0]   add_a,
    output logic [FP_W-1:0]   add_b,
    output logic              add_op,
    output logic              add_ce,
    input  logic [FP_W-1:0]   adder_result,
    output logic              result_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [FP_W-1:0]   wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W:0]   r_wr_cnt;
    logic              r_reading;
    logic              r_issue;
    logic              r_busy;
    logic              r_done;
    logic              r_add_op;
    logic [FP_W-1:0]   r_add_a;
    logic [FP_W-1:0]   r_add_b;

    logic              w_rd_fire;
    logic              w_last_rd;
    logic              w_last_wr;
    logic              w_tap;

`ifdef FEEDER_STALL_EN
    assign w_rd_fire = r_reading & ~stall;
`else
    assign w_rd_fire = r_reading;
`endif

    assign w_last_rd = (r_rd_cnt == r_len - CNT_ONE);
    assign w_last_wr = (r_wr_cnt == r_len - CNT_ONE);

    // r_issue marks the cycle the RAM presents a pair; it is captured into
    // add_a/add_b and pushed into the delay line on the same edge.
    valid_delay_line #(
        .LATENCY (LATENCY)
    ) u_vdl (
        .clk     (clk),
        .rst     (rst),
        .in_bit  (r_issue),
        .out_bit (w_tap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_reading <= 1'b0;
            r_issue   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_add_op  <= 1'b0;
            r_add_a   <= '0;
            r_add_b   <= '0;
        end else begin
            r_issue <= w_rd_fire;
            if (r_issue) begin
                r_add_a <= rd_data_a;
                r_add_b <= rd_data_b;
            end
            if (w_tap) begin
                r_wr_cnt <= r_wr_cnt + CNT_ONE;
            end

            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len    <= len;
                        r_add_op <= op_in;
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        if (len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= READ;
                            r_reading <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (w_rd_fire) begin
                        if (w_last_rd) begin
                            r_reading <= 1'b0;
                            r_state   <= DRAIN;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + CNT_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (w_tap && w_last_wr) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_en        = w_rd_fire;
    assign rd_addr      = r_rd_cnt[ADDR_W-1:0];
    assign add_a        = r_add_a;
    assign add_b        = r_add_b;
    assign add_op       = r_add_op;
    assign add_ce       = r_busy;
    assign busy         = r_busy;
    assign done         = r_done;
    assign result_valid = w_tap;
    assign wr_en        = w_tap;
    assign wr_addr      = r_wr_cnt[ADDR_W-1:0];
    assign wr_data      = adder_result;

endmodule

// File: tb/tb_fp_addsub_issue_ctrl.sv
// Directed bench for fp_addsub_issue_ctrl with a synchronous operand RAM
// and a pipelined FP add/sub model behind the controller.
`timescale 1ns/1ps
module tb_fp_addsub_issue_ctrl;

    localparam int unsigned LAT = 8;
    localparam int unsigned AW  = 4;
    localparam int          LOGN = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          op_in;
`ifdef FEEDER_STALL_EN
    logic          stall;
`endif
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data_a, rd_data_b;
    logic [31:0]   add_a, add_b;
    logic          add_op, add_ce;
    logic [31:0]   adder_result;
    logic          result_valid, wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy, done;

    always #5 clk = ~clk;

    fp_addsub_issue_ctrl #(
        .LATENCY (LAT),
        .ADDR_W  (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .op_in        (op_in),
`ifdef FEEDER_STALL_EN
        .stall        (stall),
`endif
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_op       (add_op),
        .add_ce       (add_ce),
        .adder_result (adder_result),
        .result_valid (result_valid),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done)
    );

    // single-precision <-> real, exact for the small values used here
    function automatic real sp2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:23] == 8'd0) return 0.0;
        d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // operand RAMs: data valid the cycle after rd_en
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
    end

    // adder: result appears LAT cycles after the capturing issue cycle
    logic [31:0] pipe [LAT-1];
    always @(posedge clk) begin
        pipe[0] <= add_op ? r2sp(sp2r(add_a) - sp2r(add_b)) : r2sp(sp2r(add_a) + sp2r(add_b));
        for (int k = 1; k < int'(LAT) - 1; k++) pipe[k] <= pipe[k-1];
    end
    assign adder_result = pipe[LAT-2];

    int n_chk = 0;
    int n_pass = 0;

    int n_wr, n_rd, n_done, done_cyc, busy_lo, busy_hi, rv_bad;
    int          wr_cyc   [LOGN];
    logic [AW-1:0] wr_a_log [LOGN];
    logic [31:0] wr_d_log [LOGN];
    logic [AW-1:0] rd_log   [LOGN];
    logic [6:0]  snap_ctl;
    logic [7:0]  snap_addr;
    logic [63:0] snap_ab;

    // Pulses start at cycle 0 and records what the DUT does per cycle.
    task automatic run_op(input int l, input bit op, input int maxc, input int rst_cyc,
                          input int inj1, input int inj2, input int st_lo, input int st_hi);
        n_wr = 0; n_rd = 0; n_done = 0; done_cyc = -1; busy_lo = -1; busy_hi = -1; rv_bad = 0;
        @(negedge clk);
        len = (AW+1)'(l); op_in = op; start = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk); #1;
            start = (c == inj1 || c == inj2);
            if (start) len = 5'd3;
            rst = (c == rst_cyc);
`ifdef FEEDER_STALL_EN
            stall = (c >= st_lo && c <= st_hi);
`endif
            @(negedge clk);
            if (rd_en === 1'b1) begin
                if (n_rd < LOGN) rd_log[n_rd] = rd_addr;
                n_rd++;
            end
            if (wr_en === 1'b1) begin
                if (n_wr < LOGN) begin
                    wr_cyc[n_wr] = c; wr_a_log[n_wr] = wr_addr; wr_d_log[n_wr] = wr_data;
                end
                n_wr++;
            end
            if (done === 1'b1) begin
                if (done_cyc < 0) done_cyc = c;
                n_done++;
            end
            if (busy === 1'b1) begin
                if (busy_lo < 0) busy_lo = c;
                busy_hi = c;
            end
            if (result_valid !== wr_en || add_ce !== busy) rv_bad++;
            if (c == rst_cyc + 1) begin
                snap_ctl  = {rd_en, wr_en, done, busy, add_ce, result_valid, add_op};
                snap_addr = {rd_addr, wr_addr};
                snap_ab   = {add_a, add_b};
            end
            if (done_cyc > 0 && c >= done_cyc + 6) break;
        end
        start = 1'b0; rst = 1'b0;
`ifdef FEEDER_STALL_EN
        stall = 1'b0;
`endif
        if (st_lo > st_hi) st_lo = st_hi;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++; if ({rd_en, wr_en, done, busy, add_ce, result_valid, add_op} !== 7'd0)
            $display("FAIL reset_ctl: got %b want 0000000", {rd_en, wr_en, done, busy, add_ce, result_valid, add_op}); else n_pass++;
        n_chk++; if ({rd_addr, wr_addr, add_a, add_b} !== 72'd0)
            $display("FAIL reset_data: got %h want 0", {rd_addr, wr_addr, add_a, add_b}); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if ({busy, rd_en, done} !== 3'd0)
            $display("FAIL reset_idle: got %b want 000", {busy, rd_en, done}); else n_pass++;
    endtask

    task automatic test_single_add();
        mem_a[0] = 32'h3F800000; mem_b[0] = 32'h40000000;
        run_op(1, 1'b0, 40, 0, 0, 0, 1, 0);
        n_chk++; if (n_wr !== 1) $display("FAIL t1_wr_count: got %0d want 1", n_wr); else n_pass++;
        n_chk++; if (wr_cyc[0] !== 10) $display("FAIL t1_wr_cycle: got %0d want 10", wr_cyc[0]); else n_pass++;
        n_chk++; if (wr_a_log[0] !== 4'd0) $display("FAIL t1_wr_addr: got %0d want 0", wr_a_log[0]); else n_pass++;
        n_chk++; if (wr_d_log[0] !== 32'h40400000) $display("FAIL t1_wr_data: got %h want 40400000", wr_d_log[0]); else n_pass++;
        n_chk++; if (done_cyc !== 11) $display("FAIL t1_done_cycle: got %0d want 11", done_cyc); else n_pass++;
        n_chk++; if (n_done !== 1) $display("FAIL t1_done_width: got %0d want 1", n_done); else n_pass++;
    endtask

    task automatic test_sub_len4();
        for (int i = 0; i < 16; i++) begin mem_a[i] = 32'h40400000; mem_b[i] = 32'h3F800000; end
        run_op(4, 1'b1, 40, 0, 0, 0, 1, 0);
        n_chk++; if (n_wr !== 4) $display("FAIL t2_wr_count: got %0d want 4", n_wr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (wr_cyc[i] !== 10 + i) $display("FAIL t2_wr_cycle[%0d]: got %0d want %0d", i, wr_cyc[i], 10 + i); else n_pass++;
            n_chk++; if (wr_a_log[i] !== 4'(i)) $display("FAIL t2_wr_addr[%0d]: got %0d want %0d", i, wr_a_log[i], i); else n_pass++;
            n_chk++; if (wr_d_log[i] !== 32'h40000000) $display("FAIL t2_wr_data[%0d]: got %h want 40000000", i, wr_d_log[i]); else n_pass++;
        end
        n_chk++; if (done_cyc !== 14) $display("FAIL t2_done_cycle: got %0d want 14", done_cyc); else n_pass++;
        n_chk++; if (busy_lo !== 1 || busy_hi !== 13) $display("FAIL t2_busy_span: got %0d..%0d want 1..13", busy_lo, busy_hi); else n_pass++;
        n_chk++; if (n_rd !== 4) $display("FAIL t2_rd_count: got %0d want 4", n_rd); else n_pass++;
        n_chk++; if (rv_bad !== 0) $display("FAIL t2_strobe_align: got %0d bad cycles want 0", rv_bad); else n_pass++;
    endtask

    task automatic test_len_zero();
        run_op(0, 1'b0, 20, 0, 0, 0, 1, 0);
        n_chk++; if (done_cyc !== 1) $display("FAIL t3_done_cycle: got %0d want 1", done_cyc); else n_pass++;
        n_chk++; if (n_rd !== 0 || n_wr !== 0) $display("FAIL t3_no_access: got rd=%0d wr=%0d want 0/0", n_rd, n_wr); else n_pass++;
        n_chk++; if (busy_lo !== -1) $display("FAIL t3_busy: got first busy %0d want none", busy_lo); else n_pass++;
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < 16; i++) begin mem_a[i] = r2sp(real'(i)); mem_b[i] = r2sp(real'(i)); end
        run_op(16, 1'b0, 60, 0, 5, 20, 1, 0);
        n_chk++; if (n_wr !== 16) $display("FAIL t4_wr_count: got %0d want 16", n_wr); else n_pass++;
        n_chk++; if (n_rd !== 16) $display("FAIL t4_rd_count: got %0d want 16", n_rd); else n_pass++;
        n_chk++; if (rd_log[15] !== 4'd15) $display("FAIL t4_last_rd_addr: got %0d want 15", rd_log[15]); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_chk++; if (wr_a_log[i] !== 4'(i) || wr_d_log[i] !== r2sp(2.0 * real'(i)))
                $display("FAIL t4_write[%0d]: got addr %0d data %h want addr %0d data %h", i, wr_a_log[i], wr_d_log[i], i, r2sp(2.0 * real'(i)));
            else n_pass++;
        end
        n_chk++; if (wr_d_log[15] !== 32'h41F00000) $display("FAIL t4_last_data: got %h want 41f00000", wr_d_log[15]); else n_pass++;
        n_chk++; if (wr_cyc[15] !== 25) $display("FAIL t4_last_wr_cycle: got %0d want 25", wr_cyc[15]); else n_pass++;
        n_chk++; if (done_cyc !== 26) $display("FAIL t4_done_cycle: got %0d want 26", done_cyc); else n_pass++;
        n_chk++; if (n_done !== 1) $display("FAIL t4_busy_start_ignored: got %0d done pulses want 1", n_done); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) begin mem_a[i] = r2sp(real'(i + 1)); mem_b[i] = 32'h3F800000; end
        run_op(8, 1'b1, 30, 6, 0, 0, 1, 0);
        n_chk++; if (snap_ctl !== 7'd0) $display("FAIL t5_ctl_after_rst: got %b want 0000000", snap_ctl); else n_pass++;
        n_chk++; if (snap_addr !== 8'd0 || snap_ab !== 64'd0) $display("FAIL t5_data_after_rst: got %h %h want 0", snap_addr, snap_ab); else n_pass++;
        n_chk++; if (n_wr !== 0) $display("FAIL t5_no_write: got %0d want 0", n_wr); else n_pass++;
        n_chk++; if (n_done !== 0) $display("FAIL t5_no_done: got %0d want 0", n_done); else n_pass++;
        mem_a[0] = 32'h3F800000; mem_b[0] = 32'h40000000;
        mem_a[1] = 32'h40400000; mem_b[1] = 32'h40800000;
        run_op(2, 1'b0, 40, 0, 0, 0, 1, 0);
        n_chk++; if (n_wr !== 2) $display("FAIL t5_restart_count: got %0d want 2", n_wr); else n_pass++;
        n_chk++; if (wr_d_log[0] !== 32'h40400000 || wr_d_log[1] !== 32'h40E00000)
            $display("FAIL t5_restart_data: got %h %h want 40400000 40e00000", wr_d_log[0], wr_d_log[1]); else n_pass++;
        n_chk++; if (done_cyc !== 12) $display("FAIL t5_restart_done: got %0d want 12", done_cyc); else n_pass++;
    endtask

`ifdef FEEDER_STALL_EN
    task automatic test_stall();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h3F800000; exp_d[1] = 32'h40400000; exp_d[2] = 32'h40A00000; exp_d[3] = 32'h40E00000;
        for (int i = 0; i < 4; i++) begin mem_a[i] = r2sp(real'(i + 1)); mem_b[i] = r2sp(real'(i)); end
        run_op(4, 1'b0, 40, 0, 0, 0, 2, 3);
        n_chk++; if (n_wr !== 4) $display("FAIL t6_wr_count: got %0d want 4", n_wr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (wr_a_log[i] !== 4'(i) || wr_d_log[i] !== exp_d[i])
                $display("FAIL t6_write[%0d]: got addr %0d data %h want addr %0d data %h", i, wr_a_log[i], wr_d_log[i], i, exp_d[i]);
            else n_pass++;
        end
        n_chk++; if (wr_cyc[0] !== 10 || wr_cyc[3] !== 15) $display("FAIL t6_wr_cycles: got %0d..%0d want 10..15", wr_cyc[0], wr_cyc[3]); else n_pass++;
        n_chk++; if (done_cyc !== wr_cyc[3] + 1) $display("FAIL t6_done_cycle: got %0d want %0d", done_cyc, wr_cyc[3] + 1); else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; op_in = 1'b0;
`ifdef FEEDER_STALL_EN
        stall = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        repeat (3) @(posedge clk);
        test_reset();
        test_single_add();
        test_sub_len4();
        test_len_zero();
        test_full_depth();
        test_reset_mid();
`ifdef FEEDER_STALL_EN
        test_stall();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
